cpu_cycle_stretcher: RTL and testbench

// Generates the 2 MHz CPU clock enable and the 1 MHz peripheral enables from the 32 MHz system clock.

---
 rtl/cpu_cycle_stretcher.sv | 118 +++++++++++
 tb/tb_cpu_cycle_stretcher.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_cycle_stretcher.sv
// CPU and 1 MHz clock-enable generator for the 32 MHz system clock.
// Stretches CPU cycles that hit 1 MHz devices and holds the CPU off during external-memory waits.
module cpu_cycle_stretcher #(
    parameter int unsigned DIV_LOG2   = 4,
    parameter bit          STRETCH_EN = 1'b1
) (
    input  logic clock_32,
    input  logic reset_n,
    input  logic mhz1_enable,
    input  logic ddr_enable,
    input  logic ext_wait,
    output logic cpu_clken,
    output logic mhz1_clken,
    output logic mhz1_phase,
    output logic io_cycle,
    output logic wait_active
);

    localparam int unsigned CNT_W = DIV_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        WAIT    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             start_phase;
    logic             start_phase_nxt;
    logic             ddr_q;
    logic             ddr_nxt;
    logic             io_nxt;
    logic             grant;
    logic             slot;
    logic             top_slot;
    logic             stretch_req;

    assign slot        = &cnt[DIV_LOG2-1:0];
    assign top_slot    = slot & cnt[DIV_LOG2];
    assign stretch_req = STRETCH_EN & mhz1_enable;
    assign mhz1_phase  = cnt[DIV_LOG2];

    // Free-running phase counter, FSM state and registered enables
    always_ff @(posedge clock_32 or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            state       <= IDLE;
            start_phase <= 1'b0;
            ddr_q       <= 1'b0;
            cpu_clken   <= 1'b0;
            mhz1_clken  <= 1'b0;
            io_cycle    <= 1'b0;
            wait_active <= 1'b0;
        end else begin
            cnt         <= cnt + CNT_W'(1);
            state       <= state_nxt;
            start_phase <= start_phase_nxt;
            ddr_q       <= ddr_nxt;
            cpu_clken   <= grant;
            mhz1_clken  <= &cnt;
            io_cycle    <= io_nxt;
            wait_active <= (state_nxt == WAIT);
        end
    end

    // Cycle-start sampling and grant decision; cycle start never coincides with a slot
    always_comb begin
        state_nxt       = state;
        start_phase_nxt = start_phase;
        ddr_nxt         = ddr_q;
        io_nxt          = io_cycle;
        grant           = 1'b0;

        if (cpu_clken) begin
            ddr_nxt = ddr_enable;
            io_nxt  = stretch_req;
            if (stretch_req) begin
                state_nxt       = STRETCH;
                start_phase_nxt = cnt[DIV_LOG2];
            end
        end

        case (state)
            IDLE: begin
                if (slot) begin
                    if (ddr_q && ext_wait) begin
                        state_nxt = WAIT;
                    end else begin
                        grant = 1'b1;
                    end
                end
            end
            STRETCH: begin
                // A cycle started mid-period lets the first top slot pass
                if (top_slot) begin
                    if (start_phase) begin
                        start_phase_nxt = 1'b0;
                    end else if (ddr_q && ext_wait) begin
                        state_nxt = WAIT;
                    end else begin
                        grant     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT: begin
                if (slot && !ext_wait) begin
                    grant     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_cycle_stretcher.sv
// Directed bench for cpu_cycle_stretcher: idle cadence, stretches, waits, reset and turbo build.
module tb_cpu_cycle_stretcher;

    logic clock_32;
    logic reset_n;
    logic mhz1_enable;
    logic ddr_enable;
    logic ext_wait;
    logic cpu_clken;
    logic mhz1_clken;
    logic mhz1_phase;
    logic io_cycle;
    logic wait_active;
    logic ns_cpu_clken;
    logic ns_mhz1_clken;
    logic ns_mhz1_phase;
    logic ns_io_cycle;
    logic ns_wait_active;

    int checks = 0;
    int errors = 0;

    cpu_cycle_stretcher #(.DIV_LOG2(4), .STRETCH_EN(1'b1)) u_dut (
        .clock_32    (clock_32),
        .reset_n     (reset_n),
        .mhz1_enable (mhz1_enable),
        .ddr_enable  (ddr_enable),
        .ext_wait    (ext_wait),
        .cpu_clken   (cpu_clken),
        .mhz1_clken  (mhz1_clken),
        .mhz1_phase  (mhz1_phase),
        .io_cycle    (io_cycle),
        .wait_active (wait_active)
    );

    cpu_cycle_stretcher #(.DIV_LOG2(4), .STRETCH_EN(1'b0)) u_dut_ns (
        .clock_32    (clock_32),
        .reset_n     (reset_n),
        .mhz1_enable (mhz1_enable),
        .ddr_enable  (ddr_enable),
        .ext_wait    (ext_wait),
        .cpu_clken   (ns_cpu_clken),
        .mhz1_clken  (ns_mhz1_clken),
        .mhz1_phase  (ns_mhz1_phase),
        .io_cycle    (ns_io_cycle),
        .wait_active (ns_wait_active)
    );

    initial clock_32 = 1'b0;
    always #5 clock_32 = ~clock_32;

    // Clocks until the next cpu_clken (-1 on timeout), with io/wait occupancy and ext_wait shaping
    task automatic run_cycle(input int max, input int raise_at, input int drop_at,
                             output int n, output int io_cnt, output int wt_cnt,
                             output bit mclk, output bit phase);
        n = -1; io_cnt = 0; wt_cnt = 0; mclk = 1'b0; phase = 1'b0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clock_32);
            if (io_cycle) io_cnt++;
            if (wait_active) wt_cnt++;
            if (cpu_clken) begin
                n = i; mclk = mhz1_clken; phase = mhz1_phase;
                break;
            end
            if (i == raise_at) ext_wait = 1'b1;
            if (i == drop_at) ext_wait = 1'b0;
        end
    endtask

    task automatic align(input bit at_zero, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock_32);
            if (cpu_clken && (mhz1_clken == at_zero)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n, io, wt; bit mc, ph;
        reset_n = 1'b0;
        repeat (3) @(negedge clock_32);
        checks++;
        if ({cpu_clken, mhz1_clken, mhz1_phase, io_cycle, wait_active} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 00000",
                {cpu_clken, mhz1_clken, mhz1_phase, io_cycle, wait_active});
        end
        checks++;
        if ({ns_cpu_clken, ns_mhz1_clken, ns_mhz1_phase, ns_io_cycle, ns_wait_active} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs_ns got %b want 00000",
                {ns_cpu_clken, ns_mhz1_clken, ns_mhz1_phase, ns_io_cycle, ns_wait_active});
        end
        reset_n = 1'b1;
        run_cycle(100, -1, -1, n, io, wt, mc, ph);
        checks++;
        if (n != 16) begin errors++; $display("FAIL reset_first_clken got %0d want 16", n); end
        checks++;
        if (ph !== 1'b1) begin errors++; $display("FAIL reset_first_phase got %0d want 1", ph); end
    endtask

    task automatic test_idle;
        int n, io, wt, c_cpu, c_m1, c_ph; bit mc, ph;
        run_cycle(100, -1, -1, n, io, wt, mc, ph);
        checks++;
        if (n != 16 || mc !== 1'b1 || ph !== 1'b0) begin
            errors++; $display("FAIL idle_cnt0 got n=%0d m1=%0d ph=%0d want 16 1 0", n, mc, ph);
        end
        run_cycle(100, -1, -1, n, io, wt, mc, ph);
        checks++;
        if (n != 16 || mc !== 1'b0 || ph !== 1'b1) begin
            errors++; $display("FAIL idle_cnt16 got n=%0d m1=%0d ph=%0d want 16 0 1", n, mc, ph);
        end
        c_cpu = 0; c_m1 = 0; c_ph = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock_32);
            if (cpu_clken) c_cpu++;
            if (mhz1_clken) c_m1++;
            if (mhz1_phase) c_ph++;
        end
        checks++;
        if (c_cpu != 4) begin errors++; $display("FAIL idle_cpu_count got %0d want 4", c_cpu); end
        checks++;
        if (c_m1 != 2) begin errors++; $display("FAIL idle_mhz1_count got %0d want 2", c_m1); end
        checks++;
        if (c_ph != 32) begin errors++; $display("FAIL idle_phase_high got %0d want 32", c_ph); end
    endtask

    task automatic test_stretch_aligned;
        int n, io, wt; bit mc, ph, ok;
        align(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL align_aligned got 0 want 1"); end
        mhz1_enable = 1'b1;
        run_cycle(100, -1, -1, n, io, wt, mc, ph);
        mhz1_enable = 1'b0;
        checks++;
        if (n != 32 || mc !== 1'b1) begin
            errors++; $display("FAIL stretch_aligned_len got n=%0d m1=%0d want 32 1", n, mc);
        end
        checks++;
        if (io != 32) begin errors++; $display("FAIL stretch_aligned_io got %0d want 32", io); end
        @(negedge clock_32);
        checks++;
        if (io_cycle !== 1'b0) begin errors++; $display("FAIL stretch_io_fall got %0d want 0", io_cycle); end
    endtask

    task automatic test_stretch_misaligned;
        int n, io, wt; bit mc, ph, ok;
        align(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL align_misaligned got 0 want 1"); end
        mhz1_enable = 1'b1;
        run_cycle(100, -1, -1, n, io, wt, mc, ph);
        mhz1_enable = 1'b0;
        checks++;
        if (n != 48 || mc !== 1'b1) begin
            errors++; $display("FAIL stretch_mis_len got n=%0d m1=%0d want 48 1", n, mc);
        end
        checks++;
        if (io != 48) begin errors++; $display("FAIL stretch_mis_io got %0d want 48", io); end
    endtask

    task automatic test_ext_wait;
        int n, io, wt; bit mc, ph, ok;
        align(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL align_wait got 0 want 1"); end
        ddr_enable = 1'b1;
        ext_wait   = 1'b1;
        run_cycle(100, -1, 20, n, io, wt, mc, ph);
        ddr_enable = 1'b0;
        ext_wait   = 1'b0;
        checks++;
        if (n != 32) begin errors++; $display("FAIL wait_len got %0d want 32", n); end
        checks++;
        if (wt != 16 || io != 0) begin
            errors++; $display("FAIL wait_active_len got wt=%0d io=%0d want 16 0", wt, io);
        end
    endtask

    task automatic test_stretch_then_wait;
        int n, io, wt; bit mc, ph, ok;
        align(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL align_combo got 0 want 1"); end
        mhz1_enable = 1'b1;
        ddr_enable  = 1'b1;
        run_cycle(100, 31, 32, n, io, wt, mc, ph);
        mhz1_enable = 1'b0;
        ddr_enable  = 1'b0;
        ext_wait    = 1'b0;
        checks++;
        if (n != 48 || mc !== 1'b0) begin
            errors++; $display("FAIL combo_len got n=%0d m1=%0d want 48 0", n, mc);
        end
        checks++;
        if (wt != 16 || io != 48) begin
            errors++; $display("FAIL combo_flags got wt=%0d io=%0d want 16 48", wt, io);
        end
    endtask

    task automatic test_wait_ignored;
        int n, io, wt; bit mc, ph, ok;
        align(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL align_ignored got 0 want 1"); end
        ext_wait = 1'b1;
        repeat (5) @(negedge clock_32);
        ddr_enable = 1'b1;
        run_cycle(100, -1, -1, n, io, wt, mc, ph);
        ddr_enable = 1'b0;
        ext_wait   = 1'b0;
        checks++;
        if (n != 11 || wt != 0) begin
            errors++; $display("FAIL wait_ignored got n=%0d wt=%0d want 11 0", n, wt);
        end
    endtask

    task automatic test_no_stretch_build;
        int ns_pulses, ns_io, main_io; bit ok;
        align(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL align_ns got 0 want 1"); end
        mhz1_enable = 1'b1;
        ns_pulses = 0; ns_io = 0; main_io = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock_32);
            if (ns_cpu_clken) ns_pulses++;
            if (ns_io_cycle) ns_io++;
            if (io_cycle) main_io++;
        end
        mhz1_enable = 1'b0;
        checks++;
        if (ns_pulses != 2) begin errors++; $display("FAIL ns_pulses got %0d want 2", ns_pulses); end
        checks++;
        if (ns_io != 0) begin errors++; $display("FAIL ns_io got %0d want 0", ns_io); end
        checks++;
        if (main_io != 32) begin errors++; $display("FAIL ns_main_io got %0d want 32", main_io); end
    endtask

    task automatic test_reset_mid_stretch;
        int n, io, wt; bit mc, ph, ok;
        align(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL align_rst got 0 want 1"); end
        mhz1_enable = 1'b1;
        repeat (20) @(negedge clock_32);
        checks++;
        if (io_cycle !== 1'b1 || mhz1_phase !== 1'b1) begin
            errors++; $display("FAIL rst_pre got io=%0d ph=%0d want 1 1", io_cycle, mhz1_phase);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_clken, mhz1_clken, mhz1_phase, io_cycle, wait_active} !== 5'b0) begin
            errors++; $display("FAIL rst_immediate got %b want 00000",
                {cpu_clken, mhz1_clken, mhz1_phase, io_cycle, wait_active});
        end
        mhz1_enable = 1'b0;
        @(negedge clock_32);
        reset_n = 1'b1;
        run_cycle(100, -1, -1, n, io, wt, mc, ph);
        checks++;
        if (n != 16 || io != 0) begin
            errors++; $display("FAIL rst_recover got n=%0d io=%0d want 16 0", n, io);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        mhz1_enable = 1'b0;
        ddr_enable  = 1'b0;
        ext_wait    = 1'b0;
        test_reset();
        test_idle();
        test_stretch_aligned();
        test_stretch_misaligned();
        test_ext_wait();
        test_stretch_then_wait();
        test_wait_ignored();
        test_no_stretch_build();
        test_reset_mid_stretch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
